// File: rtl/hc595_pkg.sv
// Shared state encoding and default sizing for the 74HC595 serial driver.
package hc595_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CLK_DIV_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH_HI,
    ST_LATCH_LO
  } state_e;

endpackage

// File: rtl/hc595_serial_driver_if.sv
// Word handshake between the display controller and the 74HC595 driver.
interface hc595_serial_driver_if
  import hc595_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] data;
  logic              load;
  logic              ready;
  logic              done;
  logic              out_en;

  modport master (output data, output load, output out_en, input ready, input done);
  modport slave  (input data, input load, input out_en, output ready, output done);

endinterface

// File: rtl/hc595_tick.sv
// Phase timer: reloads to CLK_DIV-1 on every state change and flags the last cycle of a phase.
module hc595_tick
  import hc595_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);

  localparam int unsigned      CNT_W   = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (reload) begin
      cnt_d = CNT_TOP;
    end else if (cnt != '0) begin
      cnt_d = cnt - CNT_W'(1);
    end
  end

  // tick is registered from the next count so it lines up with the registered FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      tick <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/hc595_serial_driver.sv
// Serialises a parallel word onto 74HC595 DS/SHCP/STCP pins and gates OE once a frame is latched.
module hc595_serial_driver
  import hc595_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  hc595_serial_driver_if.slave  bus,
  output logic                  DS,
  output logic                  SHCP,
  output logic                  STCP,
  output logic                  OE
);

  localparam int unsigned BC_W = $clog2(DATA_W + 1);

  state_e            state;
  state_e            state_d;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_d;
  logic [BC_W-1:0]   bit_cnt;
  logic [BC_W-1:0]   bit_cnt_d;
  logic              ds_d;
  logic              done_d;
  logic              latched;
  logic              latched_d;
  logic              ready;
  logic              done;
  logic              tick;
  logic              reload_c;

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  hc595_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .reload (reload_c),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state;
    sr_d      = sr;
    bit_cnt_d = bit_cnt;
    ds_d      = DS;
    done_d    = 1'b0;
    latched_d = latched;
    unique case (state)
      ST_IDLE: begin
        if (bus.load) begin
          state_d   = ST_SHIFT_LO;
          sr_d      = bus.data;
          bit_cnt_d = BC_W'(DATA_W);
        end
      end
      ST_SHIFT_LO: begin
        if (tick) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          sr_d      = (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
          bit_cnt_d = bit_cnt - BC_W'(1);
          state_d   = (bit_cnt == BC_W'(1)) ? ST_LATCH_HI : ST_SHIFT_LO;
        end
      end
      ST_LATCH_HI: begin
        if (tick) state_d = ST_LATCH_LO;
      end
      ST_LATCH_LO: begin
        if (tick) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          latched_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // DS tracks the head bit while shifting and holds the last bit through the latch phases
    if (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI) begin
      ds_d = head_bit(sr_d);
    end
    reload_c = (state_d != state);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      latched <= 1'b0;
      DS      <= 1'b0;
      SHCP    <= 1'b0;
      STCP    <= 1'b0;
      OE      <= 1'b1;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      sr      <= sr_d;
      bit_cnt <= bit_cnt_d;
      latched <= latched_d;
      DS      <= ds_d;
      SHCP    <= (state_d == ST_SHIFT_HI);
      STCP    <= (state_d == ST_LATCH_HI);
      OE      <= ~(latched & bus.out_en);
      ready   <= (state_d == ST_IDLE);
      done    <= done_d;
    end
  end

  assign bus.ready = ready;
  assign bus.done  = done;

endmodule

// File: doc/hc595_serial_driver.md
# hc595_serial_driver

Upstream driver for the 74HC595 shift-register stage. Accepts a parallel data word with a valid/ready handshake and serialises it onto the DS/SHCP/STCP/OE pins at a programmable bit rate. After the last bit it pulses STCP so the whole word appears on the register outputs at once. It then gates OE from a software enable. It sits between the LED/display control logic and the 74HC595 chain (the chain may be cascaded, with width DATA_W).

## Interface
- DATA_W, 8: bits per frame (8 × number of cascaded chips); ≥1
- CLK_DIV, 12: clk cycles per SHCP/STCP half-period (24 MHz clk → 1 MHz SHCP); ≥1
- MSB_FIRST, 1: 1 = data[DATA_W-1] shifted first; 0 = data[0] first

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- data  in  DATA_W  word to send; sampled only on accept
- load  in  1  request; accepted when load && ready
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse when a frame's latch completes
- out_en  in  1  1 = enable register outputs once a frame has been latched
- DS  out  1  serial data to 74HC595
- SHCP  out  1  shift clock; data shifted on rising edge
- STCP  out  1  storage clock; latch on rising edge
- OE  out  1  output enable, active-low

## Operation
- All outputs are registered.
- Reset values (rst=0, asynchronous):
  - DS=0, SHCP=0, STCP=0, OE=1, ready=1 (IDLE), done=0
  - internal `latched` flag = 0
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO.
- IDLE:
  - On load && ready: capture data into the shift register and set bit_cnt = DATA_W.
  - Go to SHIFT_LO; ready drops the next cycle.
- SHIFT_LO:
  - SHCP=0; DS = the current head bit (MSB or LSB per MSB_FIRST).
  - Held CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - SHCP=1 for CLK_DIV cycles; DS stays stable throughout.
  - On exit: advance the shift register and decrement bit_cnt.
  - If bit_cnt reaches 0, go to LATCH_HI; else go to SHIFT_LO.
- LATCH_HI:
  - SHCP=0, STCP=1 for CLK_DIV cycles; DS holds the last bit.
- LATCH_LO:
  - STCP=0 for CLK_DIV cycles.
  - Then go to IDLE; done=1 for that one cycle and `latched` is set.
- OE = ~(latched && out_en), registered. It never goes low before the first completed frame.
- load while not ready: ignored; no queueing.
- Reset mid-frame: the frame is discarded and all outputs return to their reset values immediately. `latched` clears, so OE=1 until a new frame completes.
- Widths:
  - divider counter: $clog2(CLK_DIV+1) bits, counts CLK_DIV-1 down to 0
  - bit counter: $clog2(DATA_W+1) bits
  - No wrap: counters reload on every state entry.

## Timing
- Accept at cycle 0 (load && ready sampled high). The FSM enters SHIFT_LO at cycle 1.
- Bit k (k = 0..DATA_W-1):
  - SHCP rises at cycle 1 + (2k+1)·CLK_DIV
  - DS is valid from cycle 1 + 2k·CLK_DIV
  - Setup and hold are each CLK_DIV cycles.
- STCP rises at cycle 1 + 2·DATA_W·CLK_DIV.
- done at cycle 1 + 2·(DATA_W+1)·CLK_DIV; ready=1 in the same cycle.
- Back-to-back: load held high is re-accepted on the done cycle, giving a frame period of 2·(DATA_W+1)·CLK_DIV + 1 cycles.
- OE follows out_en with 1-cycle latency. It goes low on the cycle after done if out_en=1.
- Exactly DATA_W SHCP rising edges and one STCP rising edge per frame. No edges in IDLE.

## Structure
- Package hc595_pkg:
  - FSM state enum
  - default constants: DATA_W_DEF=8, CLK_DIV_DEF=12
- Sub-module hc595_tick:
  - loadable down-counter that asserts a one-cycle `tick` when a phase of CLK_DIV cycles expires
  - the FSM reloads it on every state change
- Top level holds the FSM, the shift register, the bit counter and the OE logic.

## Test plan
- Basic frame:
  - Setup: DATA_W=8, CLK_DIV=2, MSB_FIRST=1, data=8'hF0, out_en=1, load pulsed at cycle 0.
  - DS sampled at the 8 SHCP rises = 1,1,1,1,0,0,0,0.
  - One STCP rise at cycle 33; done at cycle 37; OE=0 from cycle 38.
  - A 74HC595 model shows Q=8'hF0.
- LSB first: MSB_FIRST=0, data=8'hA5 → DS at SHCP rises = 1,0,1,0,0,1,0,1.
- Busy ignore:
  - Pulse load with data=8'h0F mid-frame of 8'hF0 → ignored; ready=0 throughout.
  - Exactly 8 SHCP rises; model output = 8'hF0.
- Reset mid-frame:
  - Assert rst low after the 4th SHCP rise → DS=0, SHCP=0, STCP=0, OE=1, ready=1 asynchronously.
  - No STCP edge occurs; the next frame of 8'h3C completes normally.
- OE gating:
  - out_en=1 before any frame → OE stays 1.
  - After the first done, toggling out_en 1→0 gives OE=1 one cycle later.
- Back-to-back: load held high with DATA_W=16, CLK_DIV=1 → the second accept occurs on the first done cycle, and done pulses are 35 cycles apart.
